// File: rtl/sr_mul_arb_pkg.sv
// sr_mul_arb_pkg: shared defaults and types for the two-requester multiplier arbiter.
package sr_mul_arb_pkg;

    localparam int W_DEF = 32;
    localparam int N_DEF = 2;

    typedef logic tag_t;

    typedef struct packed {
        logic               valid;
        tag_t               tag;
        logic [W_DEF-1:0]   data;
    } stage_t;

endpackage

// File: rtl/sr_mul_pipe.sv
// sr_mul_pipe: N-deep tagged shift register carrying products to the response demux.
module sr_mul_pipe
    import sr_mul_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  tag_t         in_tag,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output tag_t         out_tag,
    output logic [W-1:0] out_data,
    output logic         busy
);

    // Same layout as stage_t, sized to this instance's operand width
    typedef struct packed {
        logic         valid;
        tag_t         tag;
        logic [W-1:0] data;
    } stage_w_t;

    stage_w_t stage_q [N];
    stage_w_t stage_d [N];

    always_comb begin
        stage_d[0] = '{valid: in_valid, tag: in_tag, data: in_data};
        for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) stage_q[i] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N; i++) busy = busy | stage_q[i].valid;
    end

    assign out_valid = stage_q[N-1].valid;
    assign out_tag   = stage_q[N-1].tag;
    assign out_data  = stage_q[N-1].data;

endmodule

// File: rtl/sr_mul_arbiter.sv
// sr_mul_arbiter: round-robin share of one pipelined multiplier between two requesters,
// each result returned to its requester exactly N cycles after acceptance.
module sr_mul_arbiter
    import sr_mul_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [1:0][W-1:0]  req_a,
    input  logic [1:0][W-1:0]  req_b,
    output logic [1:0]         req_ready,
    output logic [1:0]         rsp_valid,
    output logic [1:0][W-1:0]  rsp_data,
    output logic               busy
);

    logic [1:0]        pending_q, pending_d;
    tag_t              prio_q, prio_d;
    logic [1:0][W-1:0] hold_q, hold_d;
    logic [1:0]        elig, grant;
    logic              grant_any;
    tag_t              grant_idx;
    logic [W-1:0]      prod;
    logic              pipe_valid;
    tag_t              pipe_tag;
    logic [W-1:0]      pipe_data;

    always_comb begin
        rsp_valid = {pipe_valid && pipe_tag, pipe_valid && !pipe_tag};
        for (int i = 0; i < 2; i++) hold_d[i] = rsp_valid[i] ? pipe_data : hold_q[i];
        rsp_data = hold_d;
    end

    // A requester may reissue in the very cycle its previous result returns
    always_comb begin
        elig      = req_valid & (~pending_q | rsp_valid);
        grant_any = rst && (elig != 2'b00);
        grant_idx = (elig == 2'b11) ? prio_q : elig[1];
        grant     = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
        prio_d    = grant_any ? ~grant_idx : prio_q;
        pending_d = grant | (pending_q & ~rsp_valid);
        prod      = req_a[grant_idx] * req_b[grant_idx];
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            prio_q    <= '0;
            hold_q    <= '0;
        end else begin
            pending_q <= pending_d;
            prio_q    <= prio_d;
            hold_q    <= hold_d;
        end
    end

    sr_mul_pipe #(.N(N), .W(W)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_any),
        .in_tag    (grant_idx),
        .in_data   (prod),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_data  (pipe_data),
        .busy      (busy)
    );

endmodule

// File: tb/tb_sr_mul_arbiter.sv
// tb_sr_mul_arbiter: scoreboard bench driving N=1, 2 and 5 instances of the shared multiplier.
module tb_sr_mul_arbiter;

    localparam int NI = 3;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 5;
    endfunction

    // Shift-and-add reference, independent of the RTL's multiply operator
    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) if (b[i]) acc = acc + ({32'b0, a} << i);
        return acc[31:0];
    endfunction

    function automatic logic [31:0] rnd_op();
        int sel;
        sel = $urandom_range(0, 11);
        return (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF :
               (sel == 2) ? 32'h8000_0000 : (sel == 3) ? 32'h1 : $urandom;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid [NI];
    logic [1:0][31:0] req_a     [NI];
    logic [1:0][31:0] req_b     [NI];
    logic [1:0]       req_ready [NI];
    logic [1:0]       rsp_valid [NI];
    logic [1:0][31:0] rsp_data  [NI];
    logic             busy      [NI];
    int               cyc   = 0;
    int               n_chk = 0;
    int               n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sr_mul_arbiter #(.N(lat(g)), .W(32)) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_a     (req_a[g]),
            .req_b     (req_b[g]),
            .req_ready (req_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .busy      (busy[g])
        );
        for (genvar r = 0; r < 2; r++) begin : g_req
            exp_t q [$];
            exp_t e;
            always @(negedge clk) begin
                if (!rst) begin
                    q.delete();
                end else begin
                    if (rsp_valid[g][r]) begin
                        n_chk++;
                        if (q.size() == 0) begin
                            n_err++;
                            $display("FAIL rsp_unexpected N=%0d req%0d cyc=%0d: got data=%h, required no response",
                                     lat(g), r, cyc, rsp_data[g][r]);
                        end else begin
                            e = q.pop_front();
                            if (e.due != cyc || rsp_data[g][r] !== e.d) begin
                                n_err++;
                                $display("FAIL rsp N=%0d req%0d: got cyc=%0d data=%h, required cyc=%0d data=%h",
                                         lat(g), r, cyc, rsp_data[g][r], e.due, e.d);
                            end
                        end
                    end else if (q.size() != 0 && q[0].due <= cyc) begin
                        n_chk++;
                        n_err++;
                        e = q.pop_front();
                        $display("FAIL rsp_missing N=%0d req%0d: got no response at cyc=%0d, required data=%h at cyc=%0d",
                                 lat(g), r, cyc, e.d, e.due);
                    end
                    if (req_valid[g][r] && req_ready[g][r])
                        q.push_back(exp_t'{cyc + lat(g), mul_ref(req_a[g][r], req_b[g][r])});
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) req_valid[k] = 2'b00;
    endtask

    task automatic issue(input int k, input int r, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        req_a[k][r] = a;
        req_b[k][r] = b;
        req_valid[k][r] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready[k][r];
            if (!ok) begin @(posedge clk); #1; end
        end
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL issue_timeout N=%0d req%0d: got no ready, required ready within 20 cycles", lat(k), r);
        end
        @(posedge clk); #1;
        req_valid[k][r] = 1'b0;
    endtask

    task automatic expect_rsp(input int k, input int r, input logic [31:0] want, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid[k][r];
        end
        n_chk++;
        if (!seen || rsp_data[k][r] !== want) begin
            n_err++;
            $display("FAIL %s N=%0d: got valid=%0b data=%h, required data=%h", name, lat(k), seen, rsp_data[k][r], want);
        end
        @(negedge clk);
        n_chk++;
        if (rsp_valid[k][r] !== 1'b0 || rsp_data[k][r] !== want) begin
            n_err++;
            $display("FAIL %s_hold N=%0d: got valid=%0b data=%h, required valid=0 data=%h",
                     name, lat(k), rsp_valid[k][r], rsp_data[k][r], want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 2'b11;
            req_a[k] = {32'd7, 32'd3};
            req_b[k] = {32'd9, 32'd5};
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk += 3;
            if (req_ready[k] !== 2'b00) begin
                n_err++;
                $display("FAIL reset_ready N=%0d: got %b, required 00", lat(k), req_ready[k]);
            end
            if (rsp_valid[k] !== 2'b00) begin
                n_err++;
                $display("FAIL reset_rsp_valid N=%0d: got %b, required 00", lat(k), rsp_valid[k]);
            end
            if (busy[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_busy N=%0d: got %b, required 0", lat(k), busy[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (req_ready[k] !== 2'b01) begin
                n_err++;
                $display("FAIL contention_first N=%0d: got %b, required 01", lat(k), req_ready[k]);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) req_valid[k] = 2'b10;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (req_ready[k] !== 2'b10) begin
                n_err++;
                $display("FAIL contention_second N=%0d: got %b, required 10", lat(k), req_ready[k]);
            end
        end
        @(posedge clk); #1;
        idle_all();
        wait_cycles(8);
    endtask

    task automatic test_basic();
        for (int k = 0; k < NI; k++) begin
            req_a[k][0] = 32'd3;
            req_b[k][0] = 32'd5;
            req_valid[k] = 2'b01;
        end
        @(negedge clk);
        n_chk++;
        if (req_ready[1] !== 2'b01) begin
            n_err++;
            $display("FAIL basic_ready N=2: got %b, required 01", req_ready[1]);
        end
        @(posedge clk); #1;
        idle_all();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_chk += 2;
            if (rsp_valid[1] !== ((i == 2) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL basic_rsp_valid N=2 t+%0d: got %b, required %b", i, rsp_valid[1], (i == 2) ? 2'b01 : 2'b00);
            end
            if (busy[1] !== (i <= 2)) begin
                n_err++;
                $display("FAIL basic_busy N=2 t+%0d: got %b, required %b", i, busy[1], i <= 2);
            end
            if (i == 2) begin
                n_chk++;
                if (rsp_data[1][0] !== 32'd15) begin
                    n_err++;
                    $display("FAIL basic_data N=2: got %0d, required 15", rsp_data[1][0]);
                end
            end
        end
        wait_cycles(6);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < NI; k++) begin
            issue(k, 1, 32'hFFFF_FFFF, 32'h2);
            expect_rsp(k, 1, 32'hFFFF_FFFE, "wrap_ffff");
            issue(k, 0, 32'h8000_0000, 32'h8000_0000);
            expect_rsp(k, 0, 32'h0, "wrap_8000");
        end
        wait_cycles(6);
    endtask

    task automatic test_back_to_back(input int k);
        int cnt, last, guard;
        cnt = 0;
        last = 0;
        guard = 0;
        req_a[k][0] = $urandom;
        req_b[k][0] = $urandom;
        req_valid[k][0] = 1'b1;
        while (cnt < 3 && guard < 4 * lat(k) + 10) begin
            @(negedge clk);
            guard++;
            if (req_ready[k][0]) begin
                if (cnt > 0) begin
                    n_chk++;
                    if (cyc - last != lat(k) || rsp_valid[k][0] !== 1'b1) begin
                        n_err++;
                        $display("FAIL b2b_spacing N=%0d: got gap=%0d rsp_valid=%b, required gap=%0d rsp_valid=1",
                                 lat(k), cyc - last, rsp_valid[k][0], lat(k));
                    end
                end
                last = cyc;
                cnt++;
                @(posedge clk); #1;
                req_a[k][0] = $urandom;
                req_b[k][0] = $urandom;
                if (cnt == 3) req_valid[k][0] = 1'b0;
            end
        end
        req_valid[k][0] = 1'b0;
        n_chk++;
        if (cnt != 3) begin
            n_err++;
            $display("FAIL b2b_count N=%0d: got %0d transfers, required 3", lat(k), cnt);
        end
        wait_cycles(lat(k) + 3);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < NI; k++) begin
            req_a[k][0] = 32'd11;
            req_b[k][0] = 32'd13;
            req_valid[k] = 2'b01;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (req_ready[k] !== 2'b01) begin
                n_err++;
                $display("FAIL midrst_issue N=%0d: got %b, required 01", lat(k), req_ready[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_a[k][0] = 32'd2;
            req_b[k][0] = 32'd9;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (busy[k] !== 1'b0 || rsp_valid[k] !== 2'b00 || req_ready[k] !== 2'b00) begin
                n_err++;
                $display("FAIL midrst_clear N=%0d: got busy=%b rsp_valid=%b ready=%b, required 0 00 00",
                         lat(k), busy[k], rsp_valid[k], req_ready[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (req_ready[k] !== 2'b01) begin
                n_err++;
                $display("FAIL midrst_reaccept N=%0d: got %b, required 01", lat(k), req_ready[k]);
            end
        end
        @(posedge clk); #1;
        idle_all();
        wait_cycles(8);
    endtask

    task automatic test_random();
        int         done [NI];
        logic [1:0] acc  [NI];
        int         guard;
        bit         all_done;
        guard = 0;
        all_done = 1'b0;
        for (int k = 0; k < NI; k++) begin
            done[k] = 0;
            req_valid[k] = 2'b11;
            for (int r = 0; r < 2; r++) begin
                req_a[k][r] = rnd_op();
                req_b[k][r] = rnd_op();
            end
        end
        while (!all_done && guard < 6000) begin
            @(negedge clk);
            guard++;
            for (int k = 0; k < NI; k++) begin
                n_chk++;
                if ($countones(req_ready[k]) > 1 || $countones(rsp_valid[k]) > 1) begin
                    n_err++;
                    $display("FAIL onehot N=%0d: got ready=%b rsp_valid=%b, required at most one bit each",
                             lat(k), req_ready[k], rsp_valid[k]);
                end
                acc[k] = req_ready[k];
            end
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) begin
                for (int r = 0; r < 2; r++) begin
                    if (acc[k][r]) begin
                        done[k]++;
                        req_a[k][r] = rnd_op();
                        req_b[k][r] = rnd_op();
                    end
                end
            end
            all_done = done[0] >= 1000 && done[1] >= 1000 && done[2] >= 1000;
        end
        idle_all();
        n_chk++;
        if (!all_done) begin
            n_err++;
            $display("FAIL random_progress: got %0d/%0d/%0d ops, required 1000 each", done[0], done[1], done[2]);
        end
        wait_cycles(10);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 2'b00;
            req_a[k] = '0;
            req_b[k] = '0;
        end
        test_reset();
        test_basic();
        test_wrap();
        for (int k = 0; k < NI; k++) test_back_to_back(k);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sr_mul_arbiter.md
# sr_mul_arbiter

Shares one pipelined N-cycle multiplier between two requesters, typically two CPU cores or a CPU core and a debug/accelerator port. It accepts at most one operation per cycle through valid/ready handshakes and arbitrates round-robin. Each accepted operation is tagged with its requester and returned to that requester as a single-cycle response pulse exactly N cycles later. The block sits beside the register-file/ALU datapath and replaces a per-core multiplier; the requesting core holds its stall until the response arrives.

## Interface

Parameters:
- N, 2, multiplier latency in cycles; legal range 1..8
- W, 32, operand and result width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  [1:0]  requester i presents an operation
- req_a  in  [1:0][W-1:0]  operand A per requester
- req_b  in  [1:0][W-1:0]  operand B per requester
- req_ready  out  [1:0]  operation accepted this cycle; combinational
- rsp_valid  out  [1:0]  one-cycle result pulse per requester
- rsp_data  out  [1:0][W-1:0]  low W bits of a*b; valid only with rsp_valid[i]
- busy  out  1  any pipeline stage holds a valid operation

## Operation

- **Handshake:** a transfer occurs in cycle t when req_valid[i] && req_ready[i]. The requester holds valid and operands stable until the transfer. Operands are sampled only in the transfer cycle.
- **Eligibility:** requester i is eligible when req_valid[i] && (!pending[i] || rsp_valid[i]). pending[i] is set on transfer and cleared on rsp_valid[i]. At most one operation per requester is in flight; a back-to-back issue in the response cycle is allowed.
- **Arbitration:** prio selects the favoured requester and resets to 0.
  - Both eligible: grant prio.
  - One eligible: grant it.
  - None eligible: no grant.
  - On any grant, prio becomes the non-granted index. With no grant, prio is unchanged.
- **Ready:** req_ready = one-hot grant or 0; at most one bit is high per cycle.
- **Arithmetic:** result = (a*b) mod 2^W, identical for signed and unsigned operands (RV32 MUL semantics).
- **Response:** rsp_valid[tag] is high for exactly one cycle; the other bit is low that cycle. rsp_data[tag] carries the result. rsp_data of a non-responding requester holds its previous value. There is no response backpressure.

## Timing

- **Latency:** exactly N cycles. A transfer in cycle t produces rsp_valid in cycle t+N.
- **Throughput:** one accepted operation per cycle aggregate. Per requester, one operation per N cycles.
- **Reset values (while rst low):**
  - rsp_valid = 0, rsp_data = 0, busy = 0, req_ready = 0
  - prio = 0, pending = 0, all stage valids = 0
- **Reset mid-operation:** in-flight operations are discarded and produce no response. After release, the first transfer is possible in the first cycle with rst high.
- **Simultaneous response and new request from the same requester:** the transfer is accepted, subject to arbitration. pending remains set.
- **Grant while the other requester's response emerges:** both events are independent and both occur.
- busy is registered: high in cycles t+1 .. t+N for each transfer at t.

## Structure

- **Package sr_mul_arb_pkg:**
  - W default constant
  - typedef tag_t (1-bit requester id)
  - typedef stage_t struct {valid, tag_t tag, logic [W-1:0] data}
- **Sub-module sr_mul_pipe:**
  - N-deep shift register of stage_t
  - Stage 0 loads {grant_any, grant_idx, a*b}; stage N-1 drives the response demux
  - Async active-low clear of valid bits and data
- **Top level:** arbitration, pending flags, prio register, ready logic, response demux.

## Test plan

- **Reset:** hold rst low with req_valid=2'b11 -> req_ready=0, rsp_valid=0, busy=0. Release, then req0 a=3 b=5 at cycle t -> rsp_valid=2'b01, rsp_data[0]=15 at t+2 (N=2).
- **Contention:** both valid at reset-release cycle -> req_ready=2'b01. Next cycle req_ready=2'b10. Responses follow in order 0 then 1, one cycle apart, each N cycles after its own transfer.
- **Wrap/width:** a=32'hFFFF_FFFF, b=32'h2 -> 32'hFFFF_FFFE. a=32'h8000_0000, b=32'h8000_0000 -> 0.
- **Back-to-back per requester:** req0 held valid continuously, req1 idle -> transfers at t, t+N, t+2N. req_ready[0] stays low between transfers. rsp_valid[0] coincides with each new transfer.
- **Reset mid-flight:** transfer at t, assert rst at t+1 for one cycle -> no rsp_valid ever emitted for that operation. pending is cleared; req0 is accepted immediately after release.
- **Parameter sweep:** repeat the contention and back-to-back scenarios with N=1 and N=5. Latency equals N exactly; a bench scoreboard checks every result against a*b mod 2^32 for 1000 random operand pairs.
